hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single pipeline clock, all state on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports id_rs, id_rt  in  5 each  ID-stage source register numbers (instr[25:21], instr[20:16]).
REQ-004 SHALL have ports id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-005 SHALL have port id_jump  in  1  ID instruction is j (Next_PC redirects next edge).
REQ-006 SHALL have ports ex_rd  in  5; ex_regwr, ex_mem2reg  in  1  EX-stage destination, write enable, load flag.
REQ-007 SHALL have ports me_rd  in  5; me_regwr  in  1  ME-stage destination and write enable.
REQ-008 SHALL have ports wb_rd  in  5; wb_regwr  in  1  WB-stage destination and write enable.
REQ-009 SHALL have port me_br_taken  in  1  branch in ME resolved taken (Ctrl_branch & ALU condition).
REQ-010 SHALL have ports pc_stall, ifid_stall  out  1  hold PC / IF_ID register.
REQ-011 SHALL have ports ifid_flush, idex_flush, exme_flush  out  1  load bubble into that pipeline register.
REQ-012 SHALL have ports fwd_a, fwd_b  out  2 each  registered EX ALU operand select: 00 regfile, 01 ME alu_out, 10 WB write data.
REQ-013 SHALL have ports id_byp_a, id_byp_b  out  1  ID read must take WB write data (same-cycle write).
REQ-014 SHALL have ports stall_cnt, flush_cnt  out  16 each  performance counters.
REQ-015 SHALL have port state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.

Function
REQ-016 SHALL define hit(x, rd, we) = we & (rd != 0) & (rd == x); register 0 SHALL never hazard or forward.
REQ-017 SHALL detect load-use = ex_regwr & ex_mem2reg & ((id_use_rs & hit(id_rs,ex_rd,1)) | (id_use_rt & hit(id_rt,ex_rd,1))).
REQ-018 SHALL, combinationally in a load-use cycle with me_br_taken=0, assert pc_stall=ifid_stall=idex_flush=1, others 0.
REQ-019 SHALL, combinationally when me_br_taken=1, assert ifid_flush=idex_flush=exme_flush=1 and pc_stall=ifid_stall=0, overriding load-use and jump.
REQ-020 SHALL, when id_jump=1 with no load-use and me_br_taken=0, assert ifid_flush=1 only.
REQ-021 SHALL, when id_jump=1 and load-use both hold, stall only; jump flush occurs in the following cycle.
REQ-022 SHALL compute next fwd_a: 01 if hit(id_rs,ex_rd,ex_regwr) and not load, else 10 if hit(id_rs,me_rd,me_regwr), else 00; fwd_b identical with id_rt; EX priority over ME.
REQ-023 SHALL register fwd_a/fwd_b each edge; on an edge where idex_flush=1 they SHALL load 00.
REQ-024 SHALL drive id_byp_a = hit(id_rs,wb_rd,wb_regwr), id_byp_b = hit(id_rt,wb_rd,wb_regwr), combinationally.
REQ-025 SHALL next-state: FLUSH if me_br_taken; else STALL if load-use; else RUN; from any state.
REQ-026 SHALL keep STALL at most one consecutive cycle for one load; a second STALL cycle SHALL occur only for a new load-use condition.
REQ-027 SHALL increment stall_cnt on each edge with pc_stall=1 and flush_cnt on each edge with ifid_flush=1, both saturating at 16'hFFFF.
REQ-028 SHALL produce all control outputs with zero latency; fwd_a/fwd_b with one-cycle latency aligned to EX.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=RUN, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0.
REQ-030 SHALL, while rst_n=0, drive all stall/flush outputs to 0 regardless of inputs.
REQ-031 SHALL, on reset assertion mid-stall or mid-flush, abandon the event; first post-reset edge SHALL evaluate inputs fresh.

Verification
REQ-032 SHALL test lw $8 in EX, ID add reading rs=$8 -> pc_stall=ifid_stall=idex_flush=1 one cycle, state=01, stall_cnt=1, next edge fwd_a=10.
REQ-033 SHALL test ex_rd=$9 regwr non-load, id_rt=$9 -> no stall, next edge fwd_b=01; with me_rd=$9 also -> still 01.
REQ-034 SHALL test me_br_taken=1 concurrent with load-use -> three flushes, no stall, state=10, flush_cnt+1, fwd=00.
REQ-035 SHALL test id_rs=0, ex_rd=0 load -> no stall, fwd_a=00.
REQ-036 SHALL test wb_rd=$5 regwr, id_rs=$5 -> id_byp_a=1 same cycle; id_jump=1 -> ifid_flush=1 only.
REQ-037 SHALL test preload 65535 stalls -> stall_cnt holds 16'hFFFF; rst_n low mid-cycle -> counters 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage MIPS pipeline: load-use stall, branch/jump flush,
// registered EX operand forwarding, ID write-through bypass and event counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_jump,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwr,
    input  logic        ex_mem2reg,
    input  logic [4:0]  me_rd,
    input  logic        me_regwr,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwr,
    input  logic        me_br_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exme_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        id_byp_a,
    output logic        id_byp_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state
);

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_ME = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // Register 0 is hard-wired zero, so it never produces a dependency.
    function automatic logic hit(input logic [REG_W-1:0] x,
                                 input logic [REG_W-1:0] rd,
                                 input logic             we);
        return we & (rd != '0) & (rd == x);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // A load result is not ready in EX, so only ALU results forward from there.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] erd,
                                           input logic             ewe,
                                           input logic             eld,
                                           input logic [REG_W-1:0] mrd,
                                           input logic             mwe);
        if (hit(src, erd, ewe) && !eld)
            return FWD_ME;
        else if (hit(src, mrd, mwe))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    // ---- ID-stage decision (combinational, zero latency) ----
    // One stall per load is guaranteed by idex_flush: the bubble pushes the load
    // out of EX, so any load-use seen on the next cycle belongs to a new load.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exme_flush  = 1'b0;
        state_d     = ST_RUN;

        load_use = ex_regwr & ex_mem2reg &
                   ((id_use_rs & hit(id_rs, ex_rd, 1'b1)) |
                    (id_use_rt & hit(id_rt, ex_rd, 1'b1)));

        if (me_br_taken)
            state_d = ST_FLUSH;
        else if (load_use)
            state_d = ST_STALL;

        if (rst_n) begin
            if (me_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exme_flush = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end

        fwd_a_d = idex_flush ? FWD_RF
                             : fwd_sel(id_rs, ex_rd, ex_regwr, ex_mem2reg, me_rd, me_regwr);
        fwd_b_d = idex_flush ? FWD_RF
                             : fwd_sel(id_rt, ex_rd, ex_regwr, ex_mem2reg, me_rd, me_regwr);

        stall_cnt_d = pc_stall   ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = ifid_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    assign id_byp_a = hit(id_rs, wb_rd, wb_regwr);
    assign id_byp_b = hit(id_rt, wb_rd, wb_regwr);

    // ---- ID/EX boundary: state, forwarding selects and counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd, me_rd, wb_rd;
    logic        id_use_rs, id_use_rt, id_jump;
    logic        ex_regwr, ex_mem2reg, me_regwr, wb_regwr, me_br_taken;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, exme_flush;
    logic [1:0]  fwd_a, fwd_b, state;
    logic        id_byp_a, id_byp_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic [4:0]  act_ctrl;

    int errors = 0;
    int checks = 0;

    // model state
    int m_state, m_fa, m_fb, m_sc, m_fc;

    always #5 clk = ~clk;

    assign act_ctrl = {pc_stall, ifid_stall, ifid_flush, idex_flush, exme_flush};

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jump(id_jump),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_mem2reg(ex_mem2reg),
        .me_rd(me_rd), .me_regwr(me_regwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .me_br_taken(me_br_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exme_flush(exme_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    // ---------------- reference model ----------------
    function automatic bit ld_use();
        return ex_regwr && ex_mem2reg && (ex_rd != 0) &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_flush, exme_flush}
    function automatic logic [4:0] exp_ctrl();
        if (!rst_n)      return 5'b00000;
        if (me_br_taken) return 5'b00111;
        if (ld_use())    return 5'b11010;
        if (id_jump)     return 5'b00100;
        return 5'b00000;
    endfunction

    function automatic int exp_fwd(input logic [4:0] src);
        if (ex_regwr && !ex_mem2reg && ex_rd != 0 && ex_rd == src) return 1;
        if (me_regwr && me_rd != 0 && me_rd == src) return 2;
        return 0;
    endfunction

    function automatic bit exp_byp(input logic [4:0] src);
        return wb_regwr && (wb_rd != 0) && (wb_rd == src);
    endfunction

    task automatic model_reset();
        m_state = 0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs present at the edge.
    task automatic tick();
        int ns, na, nb, nsc, nfc;
        logic [4:0] c;
        c   = exp_ctrl();
        ns  = me_br_taken ? 2 : (ld_use() ? 1 : 0);
        na  = c[1] ? 0 : exp_fwd(id_rs);
        nb  = c[1] ? 0 : exp_fwd(id_rt);
        nsc = (c[4] && m_sc < 65535) ? m_sc + 1 : m_sc;
        nfc = (c[2] && m_fc < 65535) ? m_fc + 1 : m_fc;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_state = ns; m_fa = na; m_fb = nb; m_sc = nsc; m_fc = nfc;
        end else begin
            model_reset();
        end
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_jump = 0;
        ex_rd = 0; ex_regwr = 0; ex_mem2reg = 0;
        me_rd = 0; me_regwr = 0; wb_rd = 0; wb_regwr = 0; me_br_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        ex_rd = 8; ex_regwr = 1; ex_mem2reg = 1; id_rs = 8; id_use_rs = 1;
        me_br_taken = 1; id_jump = 1;
        @(posedge clk);
        #1;
        checks++;
        if (act_ctrl !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", act_ctrl);
        end
        checks++;
        if ({state, fwd_a, fwd_b} !== 6'b0) begin
            errors++; $display("FAIL reset_regs: state=%b fwd_a=%b fwd_b=%b want 0", state, fwd_a, fwd_b);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: stall=%0d flush=%0d want 0", stall_cnt, flush_cnt);
        end
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_rd = 8; ex_regwr = 1; ex_mem2reg = 1; id_rs = 8; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b11010) begin
            errors++; $display("FAIL load_use_ctrl: got %b want 11010", act_ctrl);
        end
        tick();
        checks++;
        if (state !== 2'b01 || stall_cnt !== 16'd1 || fwd_a !== 2'b00) begin
            errors++; $display("FAIL load_use_edge: state=%b stall_cnt=%0d fwd_a=%b want 01 1 00", state, stall_cnt, fwd_a);
        end
        // load now in ME, bubble in EX
        ex_regwr = 0; ex_mem2reg = 0; ex_rd = 0; me_rd = 8; me_regwr = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b00000) begin
            errors++; $display("FAIL load_use_once: got %b want 00000", act_ctrl);
        end
        tick();
        checks++;
        if (fwd_a !== 2'b10 || state !== 2'b00 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_fwd: fwd_a=%b state=%b stall_cnt=%0d want 10 00 1", fwd_a, state, stall_cnt);
        end
    endtask

    task automatic test_fwd_ex_priority();
        do_reset();
        ex_rd = 9; ex_regwr = 1; ex_mem2reg = 0; id_rt = 9; id_use_rt = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b00000) begin
            errors++; $display("FAIL fwd_ex_nostall: got %b want 00000", act_ctrl);
        end
        tick();
        checks++;
        if (fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_ex: fwd_b=%b want 01", fwd_b);
        end
        me_rd = 9; me_regwr = 1;
        tick();
        checks++;
        if (fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_ex_over_me: fwd_b=%b want 01", fwd_b);
        end
    endtask

    task automatic test_branch_over_load();
        int fc0;
        do_reset();
        id_rt = 6; id_use_rt = 1; me_rd = 6; me_regwr = 1;
        tick();
        fc0 = m_fc;
        ex_rd = 7; ex_regwr = 1; ex_mem2reg = 1; id_rs = 7; id_use_rs = 1;
        me_br_taken = 1; id_jump = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b00111) begin
            errors++; $display("FAIL br_ctrl: got %b want 00111", act_ctrl);
        end
        tick();
        checks++;
        if (state !== 2'b10 || flush_cnt !== 16'(fc0 + 1) || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL br_edge: state=%b flush_cnt=%0d fwd=%b/%b stall_cnt=%0d want 10 %0d 00/00 0",
                               state, flush_cnt, fwd_a, fwd_b, stall_cnt, fc0 + 1);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        ex_rd = 0; ex_regwr = 1; ex_mem2reg = 1; id_rs = 0; id_use_rs = 1;
        me_rd = 0; me_regwr = 1; wb_rd = 0; wb_regwr = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b00000 || id_byp_a !== 1'b0) begin
            errors++; $display("FAIL zero_reg_ctrl: ctrl=%b byp_a=%b want 00000 0", act_ctrl, id_byp_a);
        end
        ex_mem2reg = 0;
        tick();
        checks++;
        if (fwd_a !== 2'b00 || state !== 2'b00) begin
            errors++; $display("FAIL zero_reg_fwd: fwd_a=%b state=%b want 00 00", fwd_a, state);
        end
    endtask

    task automatic test_bypass_jump();
        do_reset();
        wb_rd = 5; wb_regwr = 1; id_rs = 5; id_rt = 4;
        #1;
        checks++;
        if (id_byp_a !== 1'b1 || id_byp_b !== 1'b0) begin
            errors++; $display("FAIL wb_bypass: byp_a=%b byp_b=%b want 1 0", id_byp_a, id_byp_b);
        end
        id_jump = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b00100) begin
            errors++; $display("FAIL jump_ctrl: got %b want 00100", act_ctrl);
        end
        tick();
        checks++;
        if (flush_cnt !== 16'd1 || state !== 2'b00) begin
            errors++; $display("FAIL jump_edge: flush_cnt=%0d state=%b want 1 00", flush_cnt, state);
        end
    endtask

    task automatic test_jump_with_load();
        do_reset();
        id_jump = 1; ex_rd = 12; ex_regwr = 1; ex_mem2reg = 1; id_rt = 12; id_use_rt = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b11010) begin
            errors++; $display("FAIL jump_load_stall: got %b want 11010", act_ctrl);
        end
        tick();
        ex_regwr = 0; ex_mem2reg = 0; ex_rd = 0; me_rd = 12; me_regwr = 1;
        #1;
        checks++;
        if (act_ctrl !== 5'b00100) begin
            errors++; $display("FAIL jump_after_stall: got %b want 00100", act_ctrl);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            id_rs = 5'($urandom_range(0, 3));  id_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));  me_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_jump = ($urandom_range(0, 5) == 0);
            ex_regwr = 1'($urandom); ex_mem2reg = 1'($urandom);
            me_regwr = 1'($urandom); wb_regwr = 1'($urandom);
            me_br_taken = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (act_ctrl !== exp_ctrl() || id_byp_a !== exp_byp(id_rs) || id_byp_b !== exp_byp(id_rt)) begin
                errors++; $display("FAIL rand_comb[%0d]: ctrl=%b byp=%b%b want %b %b%b", i, act_ctrl,
                                   id_byp_a, id_byp_b, exp_ctrl(), exp_byp(id_rs), exp_byp(id_rt));
            end
            tick();
            checks++;
            if (state !== 2'(m_state) || fwd_a !== 2'(m_fa) || fwd_b !== 2'(m_fb) ||
                stall_cnt !== 16'(m_sc) || flush_cnt !== 16'(m_fc)) begin
                errors++; $display("FAIL rand_seq[%0d]: st=%b fa=%b fb=%b sc=%0d fc=%0d want %0d %0d %0d %0d %0d",
                                   i, state, fwd_a, fwd_b, stall_cnt, flush_cnt, m_state, m_fa, m_fb, m_sc, m_fc);
            end
        end
    endtask

    task automatic test_counter_sat_and_reset();
        idle_inputs();
        ex_rd = 10; ex_regwr = 1; ex_mem2reg = 1; id_rs = 10; id_use_rs = 1;
        for (int i = 0; i < 65540; i++) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF || m_sc != 65535) begin
            errors++; $display("FAIL stall_sat: got %h want ffff", stall_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'hFFFF || pc_stall !== 1'b1) begin
            errors++; $display("FAIL stall_sat_hold: cnt=%h pc_stall=%b want ffff 1", stall_cnt, pc_stall);
        end
        // reset asserted between edges while stalled, load-use still presented
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || state !== 2'b00 || act_ctrl !== 5'b00000) begin
            errors++; $display("FAIL async_reset: sc=%0d fc=%0d st=%b ctrl=%b want 0 0 00 00000",
                               stall_cnt, flush_cnt, state, act_ctrl);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (act_ctrl !== 5'b11010) begin
            errors++; $display("FAIL post_reset_fresh: got %b want 11010", act_ctrl);
        end
        tick();
        checks++;
        if (state !== 2'b01 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL post_reset_edge: st=%b sc=%0d want 01 1", state, stall_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_fwd_ex_priority();
        test_branch_over_load();
        test_zero_reg();
        test_bypass_jump();
        test_jump_with_load();
        test_random();
        test_counter_sat_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
